// File: rtl/sky130_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sky130_ram_pkg
// Description : Shared types and helpers for the sky130 RAM read-modify-write
//               adapter: RMW state encoding, the default bytes-per-word
//               constant and a byte-uniform mask test for the default width.
// Revision    : 1.0 - initial release
// ============================================================================
package sky130_ram_pkg;

    // Adapter state: IDLE accepts requests, RMW_WRITE issues the merged write.
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } rmw_state_e;

    localparam int DefaultWidth = 32;
    localparam int BytesPerWord = DefaultWidth / 8;

    // True when every byte lane of the mask is either all-0 or all-1, i.e. the
    // write can be expressed with the macro's byte enables alone.
    function automatic logic byte_uniform(input logic [DefaultWidth-1:0] mask);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < BytesPerWord; b++) begin
            if ((mask[b*8 +: 8] != 8'h00) && (mask[b*8 +: 8] != 8'hFF)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage : sky130_ram_pkg
`default_nettype wire

// File: rtl/sky130_ram_mask_merge.sv
`default_nettype none
// ============================================================================
// Module      : sky130_ram_mask_merge
// Description : Combinational helper for the RMW adapter.
//               - classifies an incoming write mask (byte-uniform / all-zero)
//               - merges captured write data into the word read from RAM
// Ports       : check_mask_i  mask to classify (live upstream mask)
//               wdata_i       captured write data
//               wmask_i       captured per-bit write mask
//               rdata_i       word returned by the RAM read
//               uniform_o     1 when every byte lane of check_mask_i is 0x00/0xFF
//               zero_o        1 when check_mask_i is all zeros
//               merged_o      (rdata_i & ~wmask_i) | (wdata_i & wmask_i)
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_ram_mask_merge #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] check_mask_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    input  logic [Width-1:0] rdata_i,
    output logic             uniform_o,
    output logic             zero_o,
    output logic [Width-1:0] merged_o
);

    localparam int c_BYTES = Width / 8;

    logic [c_BYTES-1:0] w_lane_ok;

    generate
        for (genvar b = 0; b < c_BYTES; b++) begin : g_lane
            // A lane is acceptable to the macro if it is fully on or fully off.
            assign w_lane_ok[b] = (&check_mask_i[b*8 +: 8]) | ~(|check_mask_i[b*8 +: 8]);
        end
    endgenerate

    assign uniform_o = &w_lane_ok;
    assign zero_o    = ~(|check_mask_i);
    assign merged_o  = (rdata_i & ~wmask_i) | (wdata_i & wmask_i);

endmodule : sky130_ram_mask_merge
`default_nettype wire

// File: rtl/sky130_ram_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : sky130_ram_rmw_adapter
// Description : Request-side adapter in front of a 1-port sky130 RAM wrapper.
//               Reads and byte-uniform writes pass straight through; writes
//               with a sub-byte mask become a read followed by a full-word
//               merged write. Every accepted request gets one in-order
//               response (read data or write ack).
// Ports       : clk_i/rst_i              clock, synchronous active-high reset
//               req_i/gnt_o              upstream handshake
//               we_i/addr_i/wdata_i/wmask_i  upstream request fields
//               rvalid_o/rdata_o         upstream response
//               ram_*                    prim_ram_1p-style RAM port
//               rmw_busy_o               high while the merged write is issued
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_ram_rmw_adapter
    import sky130_ram_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 2048,
    localparam int Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,
    output logic             rmw_busy_o
);

    rmw_state_e       state_q, state_d;
    logic             rvalid_q, rvalid_d;
    logic             resp_is_read_q, resp_is_read_d;
    logic [Aw-1:0]    addr_q, addr_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [Width-1:0] wmask_q, wmask_d;

    logic             w_uniform;
    logic             w_mask_zero;
    logic [Width-1:0] w_merged;

    sky130_ram_mask_merge #(
        .Width (Width)
    ) u_mask_merge (
        .check_mask_i (wmask_i),
        .wdata_i      (wdata_q),
        .wmask_i      (wmask_q),
        .rdata_i      (ram_rdata_i),
        .uniform_o    (w_uniform),
        .zero_o       (w_mask_zero),
        .merged_o     (w_merged)
    );

    assign gnt_o      = !rst_i && (state_q == IDLE);
    assign rmw_busy_o = (state_q == RMW_WRITE);
    assign rvalid_o   = rvalid_q;
    // The RAM holds its read data until the next read, so the data can be
    // taken straight from the macro in the response cycle; write acks read 0.
    assign rdata_o    = (rvalid_q && resp_is_read_q) ? ram_rdata_i : '0;

    always_comb begin
        state_d        = state_q;
        rvalid_d       = 1'b0;
        resp_is_read_d = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ram_req_o      = 1'b0;
        ram_write_o    = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        ram_wmask_o    = '0;

        // Nothing reaches the RAM while reset is asserted, which also cancels
        // a pending merged write.
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (!we_i) begin
                            ram_req_o      = 1'b1;
                            ram_addr_o     = addr_i;
                            rvalid_d       = 1'b1;
                            resp_is_read_d = 1'b1;
                        end else if (w_mask_zero) begin
                            // Nothing to write; only the ack is owed.
                            rvalid_d = 1'b1;
                        end else if (w_uniform) begin
                            ram_req_o   = 1'b1;
                            ram_write_o = 1'b1;
                            ram_addr_o  = addr_i;
                            ram_wdata_o = wdata_i;
                            ram_wmask_o = wmask_i;
                            rvalid_d    = 1'b1;
                        end else begin
                            // Sub-byte mask: fetch the old word now, write the
                            // merged word next cycle from captured copies.
                            ram_req_o = 1'b1;
                            ram_addr_o = addr_i;
                            addr_d    = addr_i;
                            wdata_d   = wdata_i;
                            wmask_d   = wmask_i;
                            state_d   = RMW_WRITE;
                        end
                    end
                end
                RMW_WRITE: begin
                    ram_req_o   = 1'b1;
                    ram_write_o = 1'b1;
                    ram_addr_o  = addr_q;
                    ram_wdata_o = w_merged;
                    ram_wmask_o = '1;
                    rvalid_d    = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            rvalid_q       <= 1'b0;
            resp_is_read_q <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
        end else begin
            state_q        <= state_d;
            rvalid_q       <= rvalid_d;
            resp_is_read_q <= resp_is_read_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
        end
    end

endmodule : sky130_ram_rmw_adapter
`default_nettype wire

// File: tb/tb_sky130_ram_rmw_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky130_ram_rmw_adapter
// Description : Self-checking bench for sky130_ram_rmw_adapter. A behavioural
//               1-port RAM sits behind the adapter; a word-level reference
//               memory plus an expected-response queue predicts every grant,
//               response and final memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sky130_ram_rmw_adapter;

    localparam int c_W  = 32;
    localparam int c_D  = 2048;
    localparam int c_AW = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [c_AW-1:0] addr = '0;
    logic [c_W-1:0]  wdata = '0;
    logic [c_W-1:0]  wmask = '0;
    logic            gnt_o, rvalid_o, ram_req_o, ram_write_o, rmw_busy_o;
    logic [c_W-1:0]  rdata_o, ram_wdata_o, ram_wmask_o;
    logic [c_AW-1:0] ram_addr_o;
    logic [c_W-1:0]  ram_rdata;

    always #5 clk = ~clk;

    sky130_ram_rmw_adapter #(.Width(c_W), .Depth(c_D)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .wmask_i     (wmask),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .ram_req_o   (ram_req_o),
        .ram_write_o (ram_write_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wmask_o (ram_wmask_o),
        .ram_rdata_i (ram_rdata),
        .rmw_busy_o  (rmw_busy_o)
    );

    // Behavioural RAM: bit-masked write, registered read data held until the
    // next read.
    logic [c_W-1:0] mem [c_D];
    always @(posedge clk) begin
        if (ram_req_o) begin
            if (ram_write_o)
                mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            else
                ram_rdata <= mem[ram_addr_o];
        end
    end

    // Reference model state.
    typedef struct { logic [c_W-1:0] data; int due; } resp_t;
    resp_t          rq[$];
    logic [c_W-1:0] ref_mem [c_D];
    int             cyc = 0;
    int             blocked = -1;
    bit             pend = 0;
    int             pend_cyc;
    logic [c_AW-1:0] pend_addr;
    logic [c_W-1:0] pend_val;
    int             n_cmp = 0;
    int             n_fail = 0;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit lanes_uniform(input logic [c_W-1:0] m);
        for (int b = 0; b < c_W / 8; b++) begin
            logic [7:0] lane;
            lane = m[b*8 +: 8];
            if (lane != 8'h00 && lane != 8'hFF) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic preload(input logic [c_AW-1:0] a, input logic [c_W-1:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // One clock cycle: drive inputs just after the edge, then check and
    // advance the model at the falling edge. Callers may add checks after.
    task automatic drive(input logic r, input logic w, input logic [c_AW-1:0] a,
                         input logic [c_W-1:0] d, input logic [c_W-1:0] m);
        bit             exp_v, mgnt;
        resp_t          head;
        logic [c_W-1:0] nv;
        @(posedge clk); #1;
        req = r; we = w; addr = a; wdata = d; wmask = m;
        cyc++;
        @(negedge clk);
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        check("rvalid", {31'b0, rvalid_o}, {31'b0, exp_v});
        if (exp_v) begin
            head = rq.pop_front();
            check("rdata", rdata_o, head.data);
        end
        mgnt = !rst && (cyc != blocked);
        check("gnt", {31'b0, gnt_o}, {31'b0, mgnt});
        if (pend && pend_cyc == cyc) begin
            if (!rst) ref_mem[pend_addr] = pend_val;
            pend = 0;
        end
        if (rst) begin
            rq.delete();
            blocked = -1;
        end else if (r && mgnt) begin
            if (!w) begin
                rq.push_back('{ref_mem[a], cyc + 1});
            end else begin
                nv = (ref_mem[a] & ~m) | (d & m);
                if (lanes_uniform(m)) begin
                    ref_mem[a] = nv;
                    rq.push_back('{32'h0, cyc + 1});
                end else begin
                    pend = 1; pend_addr = a; pend_val = nv; pend_cyc = cyc + 1;
                    blocked = cyc + 1;
                    rq.push_back('{32'h0, cyc + 2});
                end
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < c_D; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset
        rst = 1'b1;
        idle(); idle();
        check("rst_busy", {31'b0, rmw_busy_o}, 32'h0);
        check("rst_ramreq", {31'b0, ram_req_o}, 32'h0);
        rst = 1'b0;
        idle();
        check("rst_rdata", rdata_o, 32'h0);

        // Plain read
        preload(11'h005, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 11'h005, 32'h0, 32'h0);
        check("rd_ramreq", {31'b0, ram_req_o}, 32'h1);
        check("rd_ramwrite", {31'b0, ram_write_o}, 32'h0);
        check("rd_ramaddr", {21'b0, ram_addr_o}, 32'h005);
        idle();
        check("rd_data", rdata_o, 32'hDEADBEEF);

        // Byte-uniform write
        preload(11'h200, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 11'h200, 32'h000000AA, 32'h000000FF);
        check("bw_ramwrite", {31'b0, ram_write_o}, 32'h1);
        check("bw_wmask", ram_wmask_o, 32'h000000FF);
        check("bw_wdata", ram_wdata_o, 32'h000000AA);
        idle();
        drive(1'b1, 1'b0, 11'h200, 32'h0, 32'h0);
        idle();
        check("bw_readback", rdata_o, 32'hDEADBEAA);

        // Nibble write -> read-modify-write
        preload(11'h7FF, 32'h12345678);
        drive(1'b1, 1'b1, 11'h7FF, 32'h0000000F, 32'h0000000F);
        check("rmw_c0_ramreq", {31'b0, ram_req_o}, 32'h1);
        check("rmw_c0_write", {31'b0, ram_write_o}, 32'h0);
        drive(1'b1, 1'b1, 11'h123, 32'hFFFFFFFF, 32'h00000001);
        check("rmw_c1_busy", {31'b0, rmw_busy_o}, 32'h1);
        check("rmw_c1_write", {31'b0, ram_write_o}, 32'h1);
        check("rmw_c1_addr", {21'b0, ram_addr_o}, 32'h7FF);
        check("rmw_c1_wdata", ram_wdata_o, 32'h1234567F);
        check("rmw_c1_wmask", ram_wmask_o, 32'hFFFFFFFF);
        idle();
        check("rmw_c2_busy", {31'b0, rmw_busy_o}, 32'h0);
        drive(1'b1, 1'b0, 11'h7FF, 32'h0, 32'h0);
        idle();
        check("rmw_readback", rdata_o, 32'h1234567F);

        // RMW followed immediately by a continuously requested read
        preload(11'h010, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 11'h010, 32'h12345678, 32'h00F0F000);
        drive(1'b1, 1'b0, 11'h010, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 11'h010, 32'h0, 32'h0);
        check("b2b_ack_valid", {31'b0, rvalid_o}, 32'h1);
        check("b2b_ack_data", rdata_o, 32'h0);
        idle();
        check("b2b_read", rdata_o, 32'hA53555A5);

        // All-zero mask: no RAM access
        preload(11'h020, 32'h11223344);
        drive(1'b1, 1'b1, 11'h020, 32'hFFFFFFFF, 32'h0);
        check("zm_ramreq", {31'b0, ram_req_o}, 32'h0);
        idle();
        check("zm_ack", {31'b0, rvalid_o}, 32'h1);

        // Reset during RMW_WRITE cancels the write and the ack
        preload(11'h030, 32'hCAFEF00D);
        drive(1'b1, 1'b1, 11'h030, 32'h0, 32'h00000001);
        rst = 1'b1;
        idle();
        check("rstrmw_ramreq", {31'b0, ram_req_o}, 32'h0);
        rst = 1'b0;
        idle();
        check("rstrmw_busy", {31'b0, rmw_busy_o}, 32'h0);
        idle();
        check("rstrmw_mem", mem[11'h030], 32'hCAFEF00D);

        // Randomized traffic over a small address window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            logic [c_AW-1:0] a;
            logic [c_W-1:0]  m;
            int              kind;
            a = c_AW'($urandom_range(0, 7)) | (($urandom % 2) != 0 ? 11'h7F8 : 11'h000);
            kind = $urandom_range(0, 3);
            case (kind)
                0: m = 32'h0;
                1: m = {{8{$urandom % 2 == 1}}, {8{$urandom % 2 == 1}},
                        {8{$urandom % 2 == 1}}, {8{$urandom % 2 == 1}}};
                2: m = 32'hFFFFFFFF;
                default: m = $urandom;
            endcase
            drive(($urandom % 4) != 0, ($urandom % 2) != 0, a, $urandom, m);
        end
        idle(); idle(); idle();

        for (int i = 0; i < c_D; i++) begin
            check($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sky130_ram_rmw_adapter
`default_nettype wire

// File: doc/sky130_ram_rmw_adapter.md
Name: sky130_ram_rmw_adapter

Overview:
Request-side adapter between a core/bus data port and the 1-port sky130 RAM wrapper (prim_ram_1p-style port: req/write/addr/wdata/wmask, rdata returned one cycle after req). The SRAM macro only supports byte-granular write enables. This block converts any write whose bit mask is not byte-uniform into a read-modify-write sequence, and passes reads and byte-uniform writes straight through. It also generates an in-order response valid for every accepted request.

Parameters:
Width, 32, data width in bits; must be a multiple of 8.
Depth, 2048, words of RAM.
Aw, $clog2(Depth), derived local parameter; address width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_i  in  1  upstream request
gnt_o  out  1  request accepted this cycle (req_i && gnt_o)
we_i  in  1  1 = write, 0 = read
addr_i  in  Aw  word address
wdata_i  in  Width  write data
wmask_i  in  Width  per-bit write mask
rvalid_o  out  1  response valid: read data, or write completion
rdata_o  out  Width  read data; valid with rvalid_o for reads, 0 for write acks
ram_req_o  out  1  to RAM req_i
ram_write_o  out  1  to RAM write_i
ram_addr_o  out  Aw  to RAM addr_i
ram_wdata_o  out  Width  to RAM wdata_i
ram_wmask_o  out  Width  to RAM wmask_i
ram_rdata_i  in  Width  from RAM rdata_o; valid one cycle after a RAM read
rmw_busy_o  out  1  high while in RMW_WRITE (debug/perf)

Behaviour:
- States: IDLE, RMW_WRITE. Reset: state=IDLE, rvalid_o=0, rdata_o=0, all holding registers 0.
- gnt_o = !rst_i && state==IDLE (combinational). No request is accepted in RMW_WRITE.
- Byte-uniform mask: every byte lane of wmask_i is all-0 or all-1.
- IDLE, accepted read: ram_req_o=1, ram_write_o=0, addr passthrough. The next cycle gives rvalid_o=1 and rdata_o=ram_rdata_i (registered valid; rdata muxed from ram_rdata_i). Latency is 1.
- IDLE, accepted byte-uniform write: passthrough with ram_write_o=1 and ram_wmask_o=wmask_i. The next cycle gives rvalid_o=1 and rdata_o=0.
- IDLE, accepted write with a mask of all zeros: no RAM access (ram_req_o=0). An ack is still given the next cycle.
- IDLE, accepted write with a non-uniform mask:
  - Cycle 0: issue a RAM read at addr_i. Capture addr, wdata and wmask. Go to RMW_WRITE.
  - Cycle 1 (RMW_WRITE): issue a RAM write at the captured addr. Data = (ram_rdata_i & ~wmask_q) | (wdata_q & wmask_q). ram_wmask_o = all ones. rvalid_o=0. Go to IDLE.
  - Cycle 2: rvalid_o=1 (ack), rdata_o=0. A new request may be accepted in the same cycle.
- No request (or not granted): ram_req_o=0. ram_write_o, ram_addr_o, ram_wdata_o and ram_wmask_o are 0.
- Responses are strictly in acceptance order. At most one response is outstanding. No upstream backpressure on rvalid_o.
- A read issued in the cycle immediately after an RMW write returns the merged data (the RAM is write-first across cycles).
- Reset asserted in RMW_WRITE: the write is not issued (ram_req_o=0 during reset), state returns to IDLE, and no ack is produced.
- Reset asserted with a response pending: rvalid_o=0 in the following cycle. The response is dropped.
- Inputs are ignored when req_i=0. Changing inputs during RMW_WRITE has no effect (captured copies are used).

Decomposition:
- Shared package sky130_ram_pkg: state enum rmw_state_e {IDLE, RMW_WRITE}, constant BytesPerWord = Width/8, function byte_uniform(mask).
- One sub-module: sky130_ram_mask_merge (combinational). It computes byte_uniform and the merged word.
- Top-level integration instantiates this adapter directly in front of prim_sky130_ram_1p; wmask passthrough widths match.

Test Plan:
- Read at 0x005 after preloading 0xDEADBEEF: req cycle 0 with gnt=1 -> ram_req=1 and write=0 in cycle 0; rvalid=1 and rdata=0xDEADBEEF in cycle 1.
- Byte write at 0x200, wdata=0x000000AA, wmask=0x000000FF: single RAM write with mask 0x000000FF, ack in cycle 1. A later read returns 0xDEADBEAA when preloaded with 0xDEADBEEF.
- Nibble write at 0x7FF, preload 0x12345678, wdata=0x0000000F, wmask=0x0000000F:
  - Cycle 0: RAM read, gnt=1.
  - Cycle 1: gnt=0, rmw_busy=1, RAM write 0x1234567F with mask 0xFFFFFFFF.
  - Cycle 2: ack. Read-back returns 0x1234567F.
- Back-to-back: RMW write to A, then read A requested continuously. The read is granted in cycle 2 and returns the merged value in cycle 3. Response order is ack then read.
- Write with wmask=0: no RAM activity, ack next cycle, memory unchanged.
- Reset asserted in RMW_WRITE cycle: no RAM write occurs, no rvalid, gnt=1 after reset. The memory word keeps its old value.
